apb_rr_requester: RTL
=====================

Name: apb_rr_requester

Overview:
- Synthesizable APB requester that shares one APB bus between NUM_REQ internal command sources using round-robin arbitration.
- Sequences each granted command through the APB SETUP/ACCESS phases and returns read data or error on a per-requester tagged response.
- Rejects misaligned addresses locally and aborts transfers that stall past a timeout.
- Replaces the behavioural bridge as the real requester in front of the APB completer.

Parameters:
- NUM_REQ, 2, number of command sources (2..8).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width (multiple of 8).
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; the only clock.
- presetn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  command valid, one bit per requester.
- req_ready  out  NUM_REQ  command accepted, one-hot, combinational.
- req_write  in  NUM_REQ  1 = write.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*(DATA_WIDTH/8)  packed byte strobes.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr, misalignment or timeout.
- rsp_timeout  out  1  error was a timeout.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB write strobes.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (async, presetn low): all outputs 0, FSM in IDLE, round-robin pointer at requester 0 (highest priority), timeout counter 0.
- Reset mid-transfer: psel/penable drop immediately; no response is ever issued for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after the pointer (wrapping), and assert req_ready for that requester only, combinationally.
  - At that edge, latch write/addr/wdata/strb/id and advance the pointer to winner+1 mod NUM_REQ.
  - Aligned command (addr[1:0]==0): go to SETUP.
  - Misaligned command: go to RESP with rsp_err=1; no APB activity.
- SETUP (one cycle): psel=1, penable=0; paddr and pwrite driven.
  - pwdata/pstrb carry the latched values for writes; both are 0 for reads.
  - Next state is ACCESS.
- ACCESS: psel=1, penable=1; all APB outputs stable.
  - pready=1 at an edge: capture prdata (reads only) and pslverr, then go to RESP.
  - pready=0: increment the counter. When the counter reaches TIMEOUT (TIMEOUT>0), go to RESP with rsp_err=1 and rsp_timeout=1.
- RESP (one cycle): psel=penable=0, rsp_valid=1 with rsp_id and status; next state is IDLE.
  - req_ready stays low in SETUP/ACCESS/RESP.
- Latency, zero wait states: accept in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3. Each wait state adds one cycle. The next accept is possible in cycle 4.
- Output registering: all APB outputs and rsp_* are registered; only req_ready is combinational.
- Requester inputs after accept: a requester may change or drop its inputs after req_ready; the latched copy is used.
- Dropped requests: a req_valid that drops before grant is simply not served.
- Width rules: the counter is $clog2(TIMEOUT+1) bits and saturates; the pointer wraps modulo NUM_REQ.

Test Plan:
- Single read: req 0 reads 0x04, completer returns 0xDEADBEEF with no wait states → psel in cycles 1–2, penable in cycle 2, rsp_valid in cycle 3 with id=0, rdata=0xDEADBEEF, err=0.
- Write with waits: req 1 writes 0xA5A5_0001 to 0x10 with strb=0x3, pready low for 3 ACCESS cycles → pwdata/pstrb/paddr stable throughout, rsp_valid 6 cycles after accept with id=1, err=0.
- Round-robin fairness: both requesters hold req_valid high for 4 commands → grants alternate 0,1,0,1; no requester is granted twice in a row while the other is waiting.
- Errors: addr 0x3 → no psel, rsp_valid 1 cycle after accept with err=1. A completer pslverr on a read → err=1, rdata=0.
- Timeout: TIMEOUT=16, pready held low → penable high for exactly 16 cycles, then psel drops and rsp err=1, timeout=1. A following aligned read then completes normally.
- Reset during ACCESS: presetn pulsed low mid-wait → psel/penable drop asynchronously, no rsp_valid issued, and the next grant goes to requester 0.

Source files
------------

// File: rtl/apb_rr_requester.sv
// apb_rr_requester: round-robin arbiter that sequences NUM_REQ command sources onto one APB bus
module apb_rr_requester #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                              pclk,
    input  logic                              presetn,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
    output logic                              rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic                              rsp_timeout,
    output logic                              psel,
    output logic                              penable,
    output logic                              pwrite,
    output logic [ADDR_WIDTH-1:0]             paddr,
    output logic [DATA_WIDTH-1:0]             pwdata,
    output logic [DATA_WIDTH/8-1:0]           pstrb,
    input  logic [DATA_WIDTH-1:0]             prdata,
    input  logic                              pready,
    input  logic                              pslverr
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_id;
    logic [CW-1:0]   r_cnt;
    logic            w_any;
    logic [IW-1:0]   w_win;
    logic            w_write;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [SW-1:0]   w_strb;
    logic            w_timeout;

    // First valid requester at or after the pointer, scanning with wrap-around
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_any = 1'b1;
                w_win = IW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_write   = req_write[w_win];
    assign w_addr    = req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata   = req_wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
    assign w_strb    = req_strb[int'(w_win)*SW +: SW];
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    // One-hot accept strobe, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (presetn && r_state == IDLE && w_any) req_ready[w_win] = 1'b1;
    end

    // Arbitration, APB phase sequencing, wait counting and response generation
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ptr <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
                        r_id  <= w_win;
                        if (w_addr[1:0] == 2'b00) begin
                            r_state <= SETUP;
                            psel    <= 1'b1;
                            pwrite  <= w_write;
                            paddr   <= w_addr;
                            pwdata  <= w_write ? w_wdata : '0;
                            pstrb   <= w_write ? w_strb : '0;
                        end else begin
                            r_state   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_id    <= w_win;
                        end
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                    penable <= 1'b1;
                    r_cnt   <= '0;
                end
                ACCESS: begin
                    if (pready) begin
                        r_state   <= RESP;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_id;
                        rsp_err   <= pslverr;
                        rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
                    end else if (w_timeout) begin
                        r_state     <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= r_id;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
